// File: rtl/m3d_sched_pkg.sv
// Shared types and width helpers for the column-block scheduler.
package m3d_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ACC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    // Index width for a counter over n values; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Index widths for the default geometry (2 rows, 4 columns, 8 planes).
    localparam int RW = width_of(2);
    localparam int CW = width_of(4);
    localparam int BW = width_of(8);

endpackage

// File: rtl/m3d_credit_cnt.sv
// Up/down counter of column results issued but not yet drained downstream.
// Simultaneous increment and drain cancel; a drain seen at zero leaves the
// count at zero and raises a sticky underflow flag.
module m3d_credit_cnt
    import m3d_sched_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    localparam int OW = width_of(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [OW-1:0] count_o,
    output logic          at_limit_o,
    output logic          err_underflow_o
);

    logic [OW-1:0] count_q, count_d;
    logic          err_q, err_d;

    // Next count and underflow flag from this cycle's increment/drain pair.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (inc_i && !dec_i) begin
            count_d = count_q + OW'(1);
        end else if (dec_i && !inc_i) begin
            if (count_q == '0) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q - OW'(1);
            end
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o         = count_q;
    assign at_limit_o      = (count_q == OW'(MAX_OUTSTANDING));
    assign err_underflow_o = err_q;

endmodule

// File: rtl/m3d_col_block_sched.sv
// Job scheduler in front of the unshared column block: walks every
// (tile, column, row) macro, streams its bit-plane reads, commits one
// bit-serial accumulate per macro, and throttles column-group starts on
// the number of column results still outstanding downstream.
module m3d_col_block_sched
    import m3d_sched_pkg::*;
#(
    parameter int MACRO_ROW       = 2,
    parameter int MACRO_COLUMN    = 4,
    parameter int BIT_PLANES      = 8,
    parameter int TILE_CNT_WIDTH  = 8,
    parameter int MAX_OUTSTANDING = 2,
    localparam int ROW_W = width_of(MACRO_ROW),
    localparam int COL_W = width_of(MACRO_COLUMN),
    localparam int BIT_W = width_of(BIT_PLANES),
    localparam int OW    = width_of(MAX_OUTSTANDING + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      job_vld,
    output logic                      job_rdy,
    input  logic [TILE_CNT_WIDTH-1:0] job_num_tiles,
    output logic                      macro_rd_vld,
    input  logic                      macro_rd_rdy,
    output logic [ROW_W-1:0]          macro_rd_row,
    output logic [COL_W-1:0]          macro_rd_col,
    output logic [BIT_W-1:0]          macro_rd_bit,
    output logic                      macro_rd_last,
    output logic                      bit_serial_acc_vld,
    input  logic                      bit_serial_acc_rdy,
    input  logic                      col_result_fire,
    output logic                      busy,
    output logic                      done,
    output logic                      err_underflow
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MACRO_ROW - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MACRO_COLUMN - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_PLANES - 1);

    sched_state_e              state_q, state_d;
    logic [TILE_CNT_WIDTH-1:0] tiles_q, tiles_d;
    logic [TILE_CNT_WIDTH-1:0] tile_q, tile_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [BIT_W-1:0]          bit_q, bit_d;

    logic          credit_inc;
    logic          credit_full;
    logic [OW-1:0] outstanding;
    logic          rd_fire;
    logic          acc_fire;

    m3d_credit_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk             (clk),
        .rst             (rst),
        .inc_i           (credit_inc),
        .dec_i           (col_result_fire),
        .count_o         (outstanding),
        .at_limit_o      (credit_full),
        .err_underflow_o (err_underflow)
    );

    // Credits only gate the first plane of a column group's first row, so a
    // group once started always runs to completion.
    assign macro_rd_vld       = (state_q == ST_ISSUE) &&
                                !((row_q == '0) && (bit_q == '0) && credit_full);
    assign macro_rd_last      = (state_q == ST_ISSUE) && (bit_q == BIT_LAST);
    assign macro_rd_row       = row_q;
    assign macro_rd_col       = col_q;
    assign macro_rd_bit       = bit_q;
    assign bit_serial_acc_vld = (state_q == ST_ACC);
    assign job_rdy            = (state_q == ST_IDLE);
    assign busy               = (state_q != ST_IDLE);
    assign done               = (state_q == ST_DONE);

    assign rd_fire  = macro_rd_vld && macro_rd_rdy;
    assign acc_fire = bit_serial_acc_vld && bit_serial_acc_rdy;

    // Next-state and counter advance for the job walk.
    always_comb begin
        state_d    = state_q;
        tiles_d    = tiles_q;
        tile_d     = tile_q;
        col_d      = col_q;
        row_d      = row_q;
        bit_d      = bit_q;
        credit_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (job_vld) begin
                    tiles_d = job_num_tiles;
                    tile_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    bit_d   = '0;
                    state_d = (job_num_tiles == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rd_fire) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = ST_ACC;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_ACC: begin
                if (acc_fire) begin
                    state_d = ST_ISSUE;
                    if (row_q == ROW_LAST) begin
                        row_d      = '0;
                        credit_inc = 1'b1;
                        if (col_q == COL_LAST) begin
                            col_d  = '0;
                            tile_d = tile_q + TILE_CNT_WIDTH'(1);
                            if (tile_q == tiles_q - TILE_CNT_WIDTH'(1)) begin
                                state_d = ST_DRAIN;
                            end
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (outstanding == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and walk counters; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tiles_q <= '0;
            tile_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            tiles_q <= tiles_d;
            tile_q  <= tile_d;
            col_q   <= col_d;
            row_q   <= row_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: tb/tb_m3d_col_block_sched.sv
// Directed bench for the column-block scheduler (default geometry).
module tb_m3d_col_block_sched;

    logic       clk;
    logic       rst;
    logic       job_vld;
    logic       job_rdy;
    logic [7:0] job_num_tiles;
    logic       macro_rd_vld;
    logic       macro_rd_rdy;
    logic [0:0] macro_rd_row;
    logic [1:0] macro_rd_col;
    logic [2:0] macro_rd_bit;
    logic       macro_rd_last;
    logic       bit_serial_acc_vld;
    logic       bit_serial_acc_rdy;
    logic       col_result_fire;
    logic       busy;
    logic       done;
    logic       err_underflow;

    int errors = 0;
    int checks = 0;

    m3d_col_block_sched dut (
        .clk                (clk),
        .rst                (rst),
        .job_vld            (job_vld),
        .job_rdy            (job_rdy),
        .job_num_tiles      (job_num_tiles),
        .macro_rd_vld       (macro_rd_vld),
        .macro_rd_rdy       (macro_rd_rdy),
        .macro_rd_row       (macro_rd_row),
        .macro_rd_col       (macro_rd_col),
        .macro_rd_bit       (macro_rd_bit),
        .macro_rd_last      (macro_rd_last),
        .bit_serial_acc_vld (bit_serial_acc_vld),
        .bit_serial_acc_rdy (bit_serial_acc_rdy),
        .col_result_fire    (col_result_fire),
        .busy               (busy),
        .done               (done),
        .err_underflow      (err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bench-side control of the reactive drivers.
    int   cyc = 0;
    bit   auto_en = 1'b0;
    bit   man_fire = 1'b0;
    bit   coinc_en = 1'b0;
    bit   stall_en = 1'b0;
    int   stall_left = 0;
    bit   fire_sched[int];

    // Monitor state.
    logic [5:0] rd_log[$];
    int   acc_cnt = 0;
    int   fire_cnt = 0;
    int   done_cnt = 0;
    int   last_fire_cyc = 0;
    int   done_cyc = 0;
    int   hold_cnt = 0;
    int   hold_viol = 0;
    int   last_err = 0;
    bit   prev_stall = 1'b0;
    logic [5:0] prev_idx = '0;

    // Reactive drivers: ready stalls and column-result fires, updated 1 time
    // unit after each rising edge.
    initial begin
        macro_rd_rdy       = 1'b1;
        bit_serial_acc_rdy = 1'b1;
        col_result_fire    = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (stall_left > 0) begin
                macro_rd_rdy = 1'b0;
                stall_left   = stall_left - 1;
            end else if (stall_en && macro_rd_vld && macro_rd_row == 1'b1 &&
                         macro_rd_col == 2'd2 && macro_rd_bit == 3'd5) begin
                macro_rd_rdy = 1'b0;
                stall_left   = 2;
                stall_en     = 1'b0;
            end else begin
                macro_rd_rdy = 1'b1;
            end
            col_result_fire = man_fire ||
                              (auto_en && fire_sched.exists(cyc)) ||
                              (coinc_en && bit_serial_acc_vld &&
                               macro_rd_row == 1'b1 && macro_rd_col == 2'd1);
        end
    end

    // Monitor: records handshakes on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (macro_rd_vld && macro_rd_rdy) begin
                rd_log.push_back({macro_rd_row, macro_rd_col, macro_rd_bit});
                if (macro_rd_last != (macro_rd_bit == 3'd7)) last_err = last_err + 1;
            end
            if (prev_stall && ({macro_rd_row, macro_rd_col, macro_rd_bit} != prev_idx || !macro_rd_vld))
                hold_viol = hold_viol + 1;
            if (macro_rd_vld && !macro_rd_rdy && macro_rd_row == 1'b1 &&
                macro_rd_col == 2'd2 && macro_rd_bit == 3'd5)
                hold_cnt = hold_cnt + 1;
            prev_stall = macro_rd_vld && !macro_rd_rdy;
            prev_idx   = {macro_rd_row, macro_rd_col, macro_rd_bit};
            if (bit_serial_acc_vld && bit_serial_acc_rdy) begin
                acc_cnt = acc_cnt + 1;
                if (auto_en && macro_rd_row == 1'b1) fire_sched[cyc + 2] = 1'b1;
            end
            if (col_result_fire) begin
                fire_cnt      = fire_cnt + 1;
                last_fire_cyc = cyc;
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        rd_log.delete();
        fire_sched.delete();
        acc_cnt   = 0;
        fire_cnt  = 0;
        done_cnt  = 0;
        hold_cnt  = 0;
        hold_viol = 0;
        last_err  = 0;
    endtask

    // Index of first read beat that departs from col/row/bit order, or -1.
    function automatic int seq_first_bad();
        logic [5:0] exp_idx;
        int k;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 2; r++) begin
                for (int b = 0; b < 8; b++) begin
                    k = c * 16 + r * 8 + b;
                    exp_idx = {1'(r), 2'(c), 3'(b)};
                    if (k >= rd_log.size()) return k;
                    if (rd_log[k] !== exp_idx) return k;
                end
            end
        end
        if (rd_log.size() != 64) return 64;
        return -1;
    endfunction

    task automatic start_job(input logic [7:0] n);
        @(negedge clk);
        job_vld       = 1'b1;
        job_num_tiles = n;
        @(negedge clk);
        job_vld = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_fire();
        man_fire = 1'b1;
        @(negedge clk);
        man_fire = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        job_vld = 1'b0;
        job_num_tiles = '0;
        repeat (3) @(negedge clk);
        checks++; if (job_rdy !== 1'b1) begin errors++; $display("FAIL reset_job_rdy got=%b exp=1", job_rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (macro_rd_vld !== 1'b0 || bit_serial_acc_vld !== 1'b0) begin
            errors++; $display("FAIL reset_vld got rd=%b acc=%b exp=0/0", macro_rd_vld, bit_serial_acc_vld); end
        checks++; if ({macro_rd_row, macro_rd_col, macro_rd_bit, macro_rd_last} !== 7'd0) begin
            errors++; $display("FAIL reset_idx got=%b exp=0", {macro_rd_row, macro_rd_col, macro_rd_bit, macro_rd_last}); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset: done (errors so far %0d)", errors);
    endtask

    task automatic test_single_tile();
        bit ok;
        int bad;
        clear_mon();
        auto_en = 1'b1;
        start_job(8'd1);
        wait_done(400, ok);
        bad = seq_first_bad();
        checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout got=none exp=done"); end
        checks++; if (rd_log.size() != 64) begin errors++; $display("FAIL single_beats got=%0d exp=64", rd_log.size()); end
        checks++; if (bad != -1) begin errors++; $display("FAIL single_order first bad beat got=%0d exp=-1", bad); end
        checks++; if (last_err != 0) begin errors++; $display("FAIL single_rd_last got=%0d bad beats exp=0", last_err); end
        checks++; if (acc_cnt != 8) begin errors++; $display("FAIL single_acc got=%0d exp=8", acc_cnt); end
        checks++; if (fire_cnt != 4) begin errors++; $display("FAIL single_fires got=%0d exp=4", fire_cnt); end
        checks++; if (done_cnt != 1 || done_cyc <= last_fire_cyc) begin
            errors++; $display("FAIL single_done got count=%0d cyc=%0d exp count=1 after fire cyc %0d", done_cnt, done_cyc, last_fire_cyc); end
        checks++; if (job_rdy !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL single_idle got rdy=%b busy=%b exp 1/0", job_rdy, busy); end
        $display("test_single_tile: beats=%0d acc=%0d done=%0d", rd_log.size(), acc_cnt, done_cnt);
    endtask

    task automatic test_rdy_stall();
        bit ok;
        int bad;
        clear_mon();
        auto_en  = 1'b1;
        stall_en = 1'b1;
        start_job(8'd1);
        wait_done(400, ok);
        bad = seq_first_bad();
        checks++; if (!ok) begin errors++; $display("FAIL stall_done_timeout got=none exp=done"); end
        checks++; if (hold_cnt != 3) begin errors++; $display("FAIL stall_cycles got=%0d exp=3", hold_cnt); end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL stall_hold got=%0d changes exp=0", hold_viol); end
        checks++; if (rd_log.size() != 64 || bad != -1) begin
            errors++; $display("FAIL stall_beats got=%0d first_bad=%0d exp=64/-1", rd_log.size(), bad); end
        $display("test_rdy_stall: stalled=%0d beats=%0d", hold_cnt, rd_log.size());
    endtask

    task automatic test_credit_stall();
        bit ok;
        bit seen;
        clear_mon();
        auto_en = 1'b0;
        seen = 1'b0;
        start_job(8'd1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy && !macro_rd_vld && !bit_serial_acc_vld) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL credit_stall_timeout got=none exp=stall"); end
        checks++; if ({macro_rd_row, macro_rd_col, macro_rd_bit} !== {1'b0, 2'd2, 3'd0}) begin
            errors++; $display("FAIL credit_stall_idx got r=%0d c=%0d b=%0d exp r=0 c=2 b=0", macro_rd_row, macro_rd_col, macro_rd_bit); end
        repeat (3) @(negedge clk);
        checks++; if (macro_rd_vld !== 1'b0) begin errors++; $display("FAIL credit_stall_hold got vld=%b exp=0", macro_rd_vld); end
        pulse_fire();
        checks++; if (macro_rd_vld !== 1'b1) begin errors++; $display("FAIL credit_resume got vld=%b exp=1", macro_rd_vld); end
        pulse_fire();
        auto_en = 1'b1;
        wait_done(400, ok);
        checks++; if (!ok || done_cnt != 1) begin errors++; $display("FAIL credit_done got=%0d exp=1", done_cnt); end
        checks++; if (rd_log.size() != 64) begin errors++; $display("FAIL credit_beats got=%0d exp=64", rd_log.size()); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL credit_err got=%b exp=0", err_underflow); end
        $display("test_credit_stall: beats=%0d done=%0d", rd_log.size(), done_cnt);
    endtask

    task automatic test_zero_tiles();
        clear_mon();
        auto_en = 1'b0;
        @(negedge clk);
        job_vld       = 1'b1;
        job_num_tiles = 8'd0;
        @(negedge clk);
        job_vld = 1'b0;
        checks++; if (done !== 1'b1 || job_rdy !== 1'b0) begin
            errors++; $display("FAIL zero_done got done=%b rdy=%b exp 1/0", done, job_rdy); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || job_rdy !== 1'b1) begin
            errors++; $display("FAIL zero_after got done=%b rdy=%b exp 0/1", done, job_rdy); end
        repeat (3) @(negedge clk);
        checks++; if (rd_log.size() != 0 || acc_cnt != 0) begin
            errors++; $display("FAIL zero_activity got beats=%0d acc=%0d exp 0/0", rd_log.size(), acc_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
        $display("test_zero_tiles: done=%0d beats=%0d", done_cnt, rd_log.size());
    endtask

    task automatic test_coincident();
        bit ok;
        bit seen;
        clear_mon();
        auto_en  = 1'b0;
        coinc_en = 1'b1;
        seen     = 1'b0;
        start_job(8'd1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bit_serial_acc_vld && macro_rd_row == 1'b1 && macro_rd_col == 2'd1) begin
                seen = 1'b1;
                break;
            end
        end
        @(negedge clk);
        coinc_en = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL coinc_timeout got=none exp=acc col1"); end
        checks++; if (dut.outstanding !== 2'd1) begin errors++; $display("FAIL coinc_count got=%0d exp=1", dut.outstanding); end
        pulse_fire();
        checks++; if (dut.outstanding !== 2'd0 || err_underflow !== 1'b0) begin
            errors++; $display("FAIL drain_to_zero got cnt=%0d err=%b exp 0/0", dut.outstanding, err_underflow); end
        pulse_fire();
        checks++; if (dut.outstanding !== 2'd0 || err_underflow !== 1'b1) begin
            errors++; $display("FAIL underflow got cnt=%0d err=%b exp 0/1", dut.outstanding, err_underflow); end
        auto_en = 1'b1;
        wait_done(400, ok);
        checks++; if (!ok || done_cnt != 1) begin errors++; $display("FAIL coinc_done got=%0d exp=1", done_cnt); end
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got=%b exp=1", err_underflow); end
        $display("test_coincident: done=%0d err=%b", done_cnt, err_underflow);
    endtask

    task automatic test_rst_mid_job();
        bit ok;
        bit seen;
        int bad;
        clear_mon();
        auto_en = 1'b1;
        seen    = 1'b0;
        start_job(8'd1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bit_serial_acc_vld && macro_rd_col == 2'd1) begin
                seen = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL rst_mid_timeout got=none exp=acc col1"); end
        checks++; if (busy !== 1'b0 || job_rdy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_idle got busy=%b rdy=%b exp 0/1", busy, job_rdy); end
        checks++; if (macro_rd_vld !== 1'b0 || bit_serial_acc_vld !== 1'b0) begin
            errors++; $display("FAIL rst_mid_vld got rd=%b acc=%b exp 0/0", macro_rd_vld, bit_serial_acc_vld); end
        checks++; if (err_underflow !== 1'b0 || dut.outstanding !== 2'd0) begin
            errors++; $display("FAIL rst_mid_credit got err=%b cnt=%0d exp 0/0", err_underflow, dut.outstanding); end
        repeat (4) @(negedge clk);
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_cnt); end
        clear_mon();
        start_job(8'd1);
        wait_done(400, ok);
        bad = seq_first_bad();
        checks++; if (!ok || done_cnt != 1) begin errors++; $display("FAIL rst_fresh_done got=%0d exp=1", done_cnt); end
        checks++; if (rd_log.size() != 64 || bad != -1 || acc_cnt != 8) begin
            errors++; $display("FAIL rst_fresh_job got beats=%0d first_bad=%0d acc=%0d exp 64/-1/8", rd_log.size(), bad, acc_cnt); end
        $display("test_rst_mid_job: fresh beats=%0d done=%0d", rd_log.size(), done_cnt);
    endtask

    initial begin
        rst           = 1'b1;
        job_vld       = 1'b0;
        job_num_tiles = '0;
        test_reset();
        test_single_tile();
        test_rdy_stall();
        test_credit_stall();
        test_zero_tiles();
        test_coincident();
        test_rst_mid_job();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
